// File: rtl/vx_matrix_row_seq.sv
// Matrix row sequencer: expands each accepted matrix instruction into row beats and tracks matrix groups.
// Optional MATRIX_ROW_SEQ_PERF_EN adds beat and stall performance counters.
module vx_matrix_row_seq #(
    parameter int NUM_THREADS  = 4,
    parameter int XLEN         = 32,
    parameter int UUID_WIDTH   = 44,
    parameter int WIS_W        = 2,
    parameter int NR_BITS      = 6,
    parameter int M_INSTR_BITS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [UUID_WIDTH-1:0]       in_uuid,
    input  logic [WIS_W-1:0]            in_wis,
    input  logic [NUM_THREADS-1:0]      in_tmask,
    input  logic [NR_BITS-1:0]          in_rd,
    input  logic [NUM_THREADS*XLEN-1:0] in_rs1_data,
    input  logic [NUM_THREADS*XLEN-1:0] in_rs2_data,
    input  logic                        in_m_type,
    input  logic [3:0]                  in_m_row_size,
    input  logic [M_INSTR_BITS-1:0]     in_m_instr_id,
    input  logic [3:0]                  in_m_instr_cnt,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [UUID_WIDTH-1:0]       out_uuid,
    output logic [WIS_W-1:0]            out_wis,
    output logic [NUM_THREADS-1:0]      out_tmask,
    output logic [NR_BITS-1:0]          out_rd,
    output logic [NUM_THREADS*XLEN-1:0] out_rs1_data,
    output logic [NUM_THREADS*XLEN-1:0] out_rs2_data,
    output logic [3:0]                  out_row,
    output logic                        out_last,
    output logic                        grp_done,
    output logic [M_INSTR_BITS-1:0]     grp_done_id,
    output logic                        grp_err
`ifdef MATRIX_ROW_SEQ_PERF_EN
    ,
    output logic [31:0]                 perf_beats,
    output logic [31:0]                 perf_stalls
`endif
);

    typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_e;

    state_e                      state_q, state_d;
    logic [3:0]                  row_q, last_row_q;
    logic                        m_type_q;
    logic [M_INSTR_BITS-1:0]     instr_id_q;
    logic [3:0]                  instr_cnt_q;
    logic                        accept_s, out_hs_s, last_hs_s;

    logic                        grp_active_q, grp_active_d;
    logic [M_INSTR_BITS-1:0]     grp_id_q, grp_id_d;
    logic [4:0]                  grp_cnt_q, grp_cnt_d, cnt_next_s;
    logic                        grp_done_q, grp_done_d, grp_err_q, grp_err_d;
    logic [M_INSTR_BITS-1:0]     grp_done_id_q, grp_done_id_d;

    // A group of zero instructions is treated as a group of one.
    function automatic logic grp_complete(input logic [4:0] cnt, input logic [3:0] need);
        logic [4:0] lim;
        lim = (need == 4'd0) ? 5'd1 : {1'b0, need};
        return (cnt >= lim);
    endfunction

    assign accept_s  = in_valid && in_ready;
    assign out_hs_s  = out_valid && out_ready;
    assign last_hs_s = out_hs_s && out_last;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a new accept on the last beat keeps issuing without a bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept_s ? ISSUE : IDLE;
            ISSUE:   state_d = (last_hs_s && !accept_s) ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs derived from the registered state and row counter.
    always_comb begin
        out_valid = (state_q == ISSUE);
        out_last  = out_valid && (row_q == last_row_q);
        in_ready  = !out_valid || (out_ready && out_last);
    end

    // Instruction capture and row counter; counter stops at the last row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_uuid     <= '0;
            out_wis      <= '0;
            out_tmask    <= '0;
            out_rd       <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            m_type_q     <= 1'b0;
            instr_id_q   <= '0;
            instr_cnt_q  <= 4'd0;
            last_row_q   <= 4'd0;
            row_q        <= 4'd0;
        end else if (accept_s) begin
            out_uuid     <= in_uuid;
            out_wis      <= in_wis;
            out_tmask    <= in_tmask;
            out_rd       <= in_rd;
            out_rs1_data <= in_rs1_data;
            out_rs2_data <= in_rs2_data;
            m_type_q     <= in_m_type;
            instr_id_q   <= in_m_instr_id;
            instr_cnt_q  <= in_m_instr_cnt;
            last_row_q   <= in_m_type ? in_m_row_size : 4'd0;
            row_q        <= 4'd0;
        end else if (out_hs_s && !out_last) begin
            row_q        <= row_q + 4'd1;
        end else begin
            row_q        <= row_q;
        end
    end

    assign out_row = row_q;

    // Group tracker next state, evaluated on the final beat of a matrix instruction.
    always_comb begin
        grp_active_d  = grp_active_q;
        grp_id_d      = grp_id_q;
        grp_cnt_d     = grp_cnt_q;
        grp_done_d    = 1'b0;
        grp_err_d     = 1'b0;
        grp_done_id_d = grp_done_id_q;
        cnt_next_s    = 5'd0;
        if (last_hs_s && m_type_q) begin
            if (grp_active_q && (grp_id_q != instr_id_q)) begin
                grp_err_d  = 1'b1;
                cnt_next_s = 5'd1;
            end else if (grp_active_q) begin
                cnt_next_s = grp_cnt_q + 5'd1;
            end else begin
                cnt_next_s = 5'd1;
            end
            if (grp_complete(cnt_next_s, instr_cnt_q)) begin
                grp_done_d    = 1'b1;
                grp_done_id_d = instr_id_q;
                grp_active_d  = 1'b0;
                grp_cnt_d     = 5'd0;
            end else begin
                grp_active_d  = 1'b1;
                grp_id_d      = instr_id_q;
                grp_cnt_d     = cnt_next_s;
            end
        end else begin
            cnt_next_s = 5'd0;
        end
    end

    // Group tracker registers and one-cycle completion/error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grp_active_q  <= 1'b0;
            grp_id_q      <= '0;
            grp_cnt_q     <= 5'd0;
            grp_done_q    <= 1'b0;
            grp_err_q     <= 1'b0;
            grp_done_id_q <= '0;
        end else begin
            grp_active_q  <= grp_active_d;
            grp_id_q      <= grp_id_d;
            grp_cnt_q     <= grp_cnt_d;
            grp_done_q    <= grp_done_d;
            grp_err_q     <= grp_err_d;
            grp_done_id_q <= grp_done_id_d;
        end
    end

    assign grp_done    = grp_done_q;
    assign grp_err     = grp_err_q;
    assign grp_done_id = grp_done_id_q;

`ifdef MATRIX_ROW_SEQ_PERF_EN
    // Free-running wrap-around counters of output handshakes and stalled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_beats  <= 32'd0;
            perf_stalls <= 32'd0;
        end else begin
            perf_beats  <= out_hs_s ? perf_beats + 32'd1 : perf_beats;
            perf_stalls <= (out_valid && !out_ready) ? perf_stalls + 32'd1 : perf_stalls;
        end
    end
`else
`endif

endmodule

// File: tb/tb_vx_matrix_row_seq.sv
// Scoreboard bench for vx_matrix_row_seq: expected beats are queued at accept and checked on each output handshake.
module tb_vx_matrix_row_seq;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [43:0]  in_uuid = 44'd0;
    logic [1:0]   in_wis = 2'd0;
    logic [3:0]   in_tmask = 4'd0;
    logic [5:0]   in_rd = 6'd0;
    logic [127:0] in_rs1_data = 128'd0;
    logic [127:0] in_rs2_data = 128'd0;
    logic         in_m_type = 1'b0;
    logic [3:0]   in_m_row_size = 4'd0;
    logic [3:0]   in_m_instr_id = 4'd0;
    logic [3:0]   in_m_instr_cnt = 4'd0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [43:0]  out_uuid;
    logic [1:0]   out_wis;
    logic [3:0]   out_tmask;
    logic [5:0]   out_rd;
    logic [127:0] out_rs1_data;
    logic [127:0] out_rs2_data;
    logic [3:0]   out_row;
    logic         out_last;
    logic         grp_done;
    logic [3:0]   grp_done_id;
    logic         grp_err;
`ifdef MATRIX_ROW_SEQ_PERF_EN
    logic [31:0]  perf_beats;
    logic [31:0]  perf_stalls;
`endif

    vx_matrix_row_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_uuid(in_uuid), .in_wis(in_wis), .in_tmask(in_tmask), .in_rd(in_rd),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_m_type(in_m_type),
        .in_m_row_size(in_m_row_size), .in_m_instr_id(in_m_instr_id), .in_m_instr_cnt(in_m_instr_cnt),
        .out_valid(out_valid), .out_ready(out_ready), .out_uuid(out_uuid), .out_wis(out_wis),
        .out_tmask(out_tmask), .out_rd(out_rd), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_row(out_row), .out_last(out_last), .grp_done(grp_done), .grp_done_id(grp_done_id),
        .grp_err(grp_err)
`ifdef MATRIX_ROW_SEQ_PERF_EN
        , .perf_beats(perf_beats), .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [43:0]  uuid;
        logic [1:0]   wis;
        logic [3:0]   tmask;
        logic [5:0]   rd;
        logic [127:0] rs1;
        logic [127:0] rs2;
        logic [3:0]   row;
        logic         last;
        logic         mtype;
    } beat_t;

    beat_t sb[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int mhs_cyc = -10;
    int beat_total = 0;
    int stall_total = 0;
    int done_total = 0;
    int err_total = 0;
    logic [3:0] last_done_id = 4'd0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: scoreboard pop, stall stability and pulse timing.
    initial begin
        logic         hold_v;
        logic [43:0]  h_uuid;
        logic [127:0] h_rs1, h_rs2;
        logic [3:0]   h_row;
        logic         h_last;
        beat_t        e;
        hold_v = 1'b0;
        h_uuid = 44'd0; h_rs1 = 128'd0; h_rs2 = 128'd0; h_row = 4'd0; h_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    n_checks++;
                    if ({out_valid, out_uuid, out_rs1_data, out_rs2_data, out_row, out_last} !==
                        {1'b1, h_uuid, h_rs1, h_rs2, h_row, h_last}) begin
                        n_errors++;
                        $display("FAIL stall_hold: row=%0d last=%0d uuid=%h, required row=%0d last=%0d uuid=%h",
                                 out_row, out_last, out_uuid, h_row, h_last, h_uuid);
                    end
                end
                hold_v = out_valid && !out_ready;
                h_uuid = out_uuid; h_rs1 = out_rs1_data; h_rs2 = out_rs2_data;
                h_row = out_row; h_last = out_last;
                if (out_valid && !out_ready) stall_total++;
                if (out_valid && out_ready) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_beat: row=%0d uuid=%h, required no beat", out_row, out_uuid);
                    end else begin
                        e = sb.pop_front();
                        beat_total++;
                        if (e.last && e.mtype) mhs_cyc = cyc;
                        if ({out_uuid, out_wis, out_tmask, out_rd, out_rs1_data, out_rs2_data, out_row, out_last} !==
                            {e.uuid, e.wis, e.tmask, e.rd, e.rs1, e.rs2, e.row, e.last}) begin
                            n_errors++;
                            $display("FAIL beat: row=%0d last=%0d uuid=%h rs1=%h, required row=%0d last=%0d uuid=%h rs1=%h",
                                     out_row, out_last, out_uuid, out_rs1_data, e.row, e.last, e.uuid, e.rs1);
                        end
                    end
                end
                if (grp_done || grp_err) begin
                    n_checks++;
                    if (cyc !== mhs_cyc + 1) begin
                        n_errors++;
                        $display("FAIL pulse_timing: pulse at cycle %0d, required cycle %0d", cyc, mhs_cyc + 1);
                    end
                end
                if (grp_done) begin
                    done_total++;
                    last_done_id = grp_done_id;
                end
                if (grp_err) err_total++;
            end
        end
    end

    task automatic send(input logic [43:0] uuid, input logic mtype, input logic [3:0] rs,
                        input logic [3:0] id, input logic [3:0] cnt);
        beat_t b;
        int n;
        bit ok;
        in_uuid = uuid; in_wis = 2'($urandom); in_tmask = 4'($urandom); in_rd = 6'($urandom);
        in_rs1_data = {$urandom, $urandom, $urandom, $urandom};
        in_rs2_data = {$urandom, $urandom, $urandom, $urandom};
        in_m_type = mtype; in_m_row_size = rs; in_m_instr_id = id; in_m_instr_cnt = cnt;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                n = mtype ? int'(rs) + 1 : 1;
                for (int r = 0; r < n; r++) begin
                    b.uuid = uuid; b.wis = in_wis; b.tmask = in_tmask; b.rd = in_rd;
                    b.rs1 = in_rs1_data; b.rs2 = in_rs2_data; b.row = 4'(r);
                    b.last = (r == n - 1); b.mtype = mtype;
                    sb.push_back(b);
                end
                break;
            end
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL accept_timeout: in_ready=%0d, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk); #1;
            if (sb.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({in_ready, out_valid, out_last, out_row, out_uuid, out_rs1_data, grp_done, grp_done_id, grp_err} !==
            {1'b1, 1'b0, 1'b0, 4'd0, 44'd0, 128'd0, 1'b0, 4'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_values: rdy=%0d vld=%0d last=%0d row=%0d done=%0d id=%0d err=%0d, required 1 0 0 0 0 0 0",
                     in_ready, out_valid, out_last, out_row, grp_done, grp_done_id, grp_err);
        end
        #5 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_matrix_rows();
        int low;
        int d0;
        bit ok;
        low = 0; ok = 1'b0; d0 = done_total;
        send(44'h0000_0000_A01, 1'b1, 4'd3, 4'd1, 4'd1);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (!in_ready) low++;
            #1;
            if (sb.size() == 0) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok || low != 3) begin
            n_errors++;
            $display("FAIL in_ready_low: %0d cycles, required 3", low);
        end
        drain();
        n_checks++;
        if (done_total - d0 != 1 || last_done_id !== 4'd1) begin
            n_errors++;
            $display("FAIL single_group_done: %0d pulses id=%0d, required 1 pulse id=1", done_total - d0, last_done_id);
        end
    endtask

    task automatic test_non_matrix();
        int d0, e0, b0;
        d0 = done_total; e0 = err_total; b0 = beat_total;
        send(44'h0000_0000_B02, 1'b0, 4'd7, 4'd6, 4'd1);
        drain();
        n_checks++;
        if (beat_total - b0 != 1 || done_total != d0 || err_total != e0) begin
            n_errors++;
            $display("FAIL non_matrix: beats=%0d done=%0d err=%0d, required 1 0 0",
                     beat_total - b0, done_total - d0, err_total - e0);
        end
    endtask

    task automatic test_back_to_back();
        int gaps, d0, e0;
        bit ok;
        gaps = 0; ok = 1'b0; d0 = done_total; e0 = err_total;
        send(44'h0000_0000_C03, 1'b1, 4'd1, 4'd5, 4'd2);
        send(44'h0000_0000_C04, 1'b1, 4'd1, 4'd5, 4'd2);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (!out_valid) gaps++;
            #1;
            if (sb.size() == 0) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok || gaps != 0) begin
            n_errors++;
            $display("FAIL back_to_back_bubble: %0d idle cycles, required 0", gaps);
        end
        drain();
        n_checks++;
        if (done_total - d0 != 1 || last_done_id !== 4'd5 || err_total != e0) begin
            n_errors++;
            $display("FAIL group5_done: %0d pulses id=%0d err=%0d, required 1 pulse id=5 err=0",
                     done_total - d0, last_done_id, err_total - e0);
        end
    endtask

    task automatic test_group_err();
        int d0, e0;
        d0 = done_total; e0 = err_total;
        send(44'h0000_0000_D01, 1'b1, 4'd0, 4'd2, 4'd3);
        drain();
        send(44'h0000_0000_D02, 1'b1, 4'd0, 4'd7, 4'd3);
        drain();
        n_checks++;
        if (err_total - e0 != 1 || done_total != d0) begin
            n_errors++;
            $display("FAIL group_err_pulse: err=%0d done=%0d, required err=1 done=0", err_total - e0, done_total - d0);
        end
        send(44'h0000_0000_D03, 1'b1, 4'd0, 4'd7, 4'd3);
        drain();
        n_checks++;
        if (done_total != d0) begin
            n_errors++;
            $display("FAIL group7_early: done=%0d after 2 instrs, required 0", done_total - d0);
        end
        send(44'h0000_0000_D04, 1'b1, 4'd0, 4'd7, 4'd3);
        drain();
        n_checks++;
        if (done_total - d0 != 1 || last_done_id !== 4'd7 || err_total - e0 != 1) begin
            n_errors++;
            $display("FAIL group7_done: done=%0d id=%0d err=%0d, required 1 id=7 err=1",
                     done_total - d0, last_done_id, err_total - e0);
        end
    endtask

    task automatic test_stall();
        int b0, s0;
        bit ok;
        b0 = beat_total; s0 = stall_total; ok = 1'b0;
        send(44'h0000_0000_E01, 1'b1, 4'd15, 4'd9, 4'd0);
        for (int t = 0; t < 100; t++) begin
            @(posedge clk); #1;
            out_ready = ~out_ready;
            @(negedge clk); #1;
            if (sb.size() == 0) begin ok = 1'b1; break; end
        end
        out_ready = 1'b1;
        drain();
        n_checks++;
        if (!ok || beat_total - b0 != 16 || stall_total - s0 != 15) begin
            n_errors++;
            $display("FAIL stall_beats: beats=%0d stalls=%0d, required 16 15", beat_total - b0, stall_total - s0);
        end
        n_checks++;
        if (last_done_id !== 4'd9) begin
            n_errors++;
            $display("FAIL cnt0_group_done: id=%0d, required 9", last_done_id);
        end
`ifdef MATRIX_ROW_SEQ_PERF_EN
        n_checks++;
        if (perf_beats !== 32'(beat_total) || perf_stalls !== 32'(stall_total)) begin
            n_errors++;
            $display("FAIL perf_counters: beats=%0d stalls=%0d, required %0d %0d",
                     perf_beats, perf_stalls, beat_total, stall_total);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int d0, e0;
        bit ok;
        ok = 1'b0;
        send(44'h0000_0000_F01, 1'b1, 4'd0, 4'd3, 4'd2);
        drain();
        send(44'h0000_0000_F02, 1'b1, 4'd3, 4'd3, 4'd2);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid && out_row == 4'd2) begin ok = 1'b1; break; end
        end
        #1;
        reset = 1'b0;
        sb.delete();
        #1;
        n_checks++;
        if (!ok || out_valid !== 1'b0 || in_ready !== 1'b1 || grp_done_id !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_mid: vld=%0d rdy=%0d id=%0d, required 0 1 0", out_valid, in_ready, grp_done_id);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        d0 = done_total; e0 = err_total;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (done_total != d0 || err_total != e0 || grp_done !== 1'b0 || grp_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_no_pulse: done=%0d err=%0d, required 0 0", done_total - d0, err_total - e0);
        end
        send(44'h0000_0000_F03, 1'b1, 4'd1, 4'd4, 4'd1);
        drain();
        n_checks++;
        if (done_total - d0 != 1 || last_done_id !== 4'd4 || err_total != e0) begin
            n_errors++;
            $display("FAIL tracker_cleared: done=%0d id=%0d err=%0d, required 1 id=4 err=0",
                     done_total - d0, last_done_id, err_total - e0);
        end
    endtask

    initial begin
        test_reset();
        test_matrix_rows();
        test_non_matrix();
        test_back_to_back();
        test_group_err();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
